// File: rtl/synth_pkg.sv
//------------------------------------------------------------------------------
// Module      : synth_pkg
// Description : Shared synth constants and helpers (CIC sizing, PCM coding).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package synth_pkg;

    localparam int OUTPUT_BITS_DEFAULT = 12;

    // Register width needed by a second-order CIC with decimation 2^log2r
    function automatic int cic_width(input int log2r);
        return 2 * log2r + 1;
    endfunction

    // Offset-binary <-> two's complement is a flip of the MSB in either direction
    function automatic logic [OUTPUT_BITS_DEFAULT-1:0] offset_to_twos(
        input logic [OUTPUT_BITS_DEFAULT-1:0] v
    );
        return v ^ {1'b1, {(OUTPUT_BITS_DEFAULT-1){1'b0}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cic_integrator.sv
//------------------------------------------------------------------------------
// Module      : cic_integrator
// Description : WIDTH-bit wrapping accumulator with clock enable.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cic_integrator #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] acc
);

    logic [WIDTH-1:0] r_acc;

    // Modular wrap is intentional; the comb differences cancel it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + din;
        end
    end

    assign acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/pdm_decimator.sv
//------------------------------------------------------------------------------
// Module      : pdm_decimator
// Description : 1-bit PDM to signed PCM via second-order CIC, valid/ready out.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pdm_decimator
    import synth_pkg::*;
#(
    parameter int OUTPUT_BITS     = OUTPUT_BITS_DEFAULT,
    parameter int DECIMATION_LOG2 = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   pdm_in,
    output logic [OUTPUT_BITS-1:0] dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   overrun
);

    localparam int c_cic_w = cic_width(DECIMATION_LOG2);
    localparam logic [OUTPUT_BITS-1:0] c_msb = {1'b1, {(OUTPUT_BITS-1){1'b0}}};

    generate
        if (2 * DECIMATION_LOG2 != OUTPUT_BITS) begin : g_bad_param
            $error("pdm_decimator: DECIMATION_LOG2 must equal OUTPUT_BITS/2");
        end
    endgenerate

    logic                       r_pdm_q;
    logic [DECIMATION_LOG2-1:0] r_cnt;
    logic [c_cic_w-1:0]         w_int1_in;
    logic [c_cic_w-1:0]         w_int1;
    logic [c_cic_w-1:0]         w_int2;
    logic [c_cic_w-1:0]         r_c1;
    logic [c_cic_w-1:0]         r_z1;
    logic [c_cic_w-1:0]         r_c2;
    logic [c_cic_w-1:0]         r_z2;
    logic                       r_stb1;
    logic                       r_stb2;
    logic [1:0]                 r_warm;
    logic [OUTPUT_BITS-1:0]     r_dout;
    logic                       r_valid;
    logic                       r_overrun;
    logic                       w_dec_edge;
    logic [OUTPUT_BITS-1:0]     w_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pdm_q <= 1'b0;
            r_cnt   <= '0;
        end else if (en) begin
            r_pdm_q <= pdm_in;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign w_int1_in  = {{(c_cic_w-1){1'b0}}, r_pdm_q};
    assign w_dec_edge = en && (r_cnt == '1);

    cic_integrator #(.WIDTH(c_cic_w)) u_int1 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .din (w_int1_in),
        .acc (w_int1)
    );

    cic_integrator #(.WIDTH(c_cic_w)) u_int2 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .din (w_int1),
        .acc (w_int2)
    );

    // Combs run off their strobes only, so an issued decimation always completes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c1   <= '0;
            r_z1   <= '0;
            r_c2   <= '0;
            r_z2   <= '0;
            r_stb1 <= 1'b0;
            r_stb2 <= 1'b0;
        end else begin
            r_stb1 <= w_dec_edge;
            r_stb2 <= r_stb1;
            if (w_dec_edge) begin
                r_c1 <= w_int2 - r_z1;
                r_z1 <= w_int2;
            end
            if (r_stb1) begin
                r_c2 <= r_c1 - r_z2;
                r_z2 <= r_c1;
            end
        end
    end

    // Full-scale DC lands exactly on 2^OUTPUT_BITS, one code past the top
    assign w_sat = (|r_c2[c_cic_w-1:OUTPUT_BITS]) ? '1 : r_c2[OUTPUT_BITS-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm    <= '0;
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_stb2) begin
            if (r_warm < 2'd2) begin
                r_warm <= r_warm + 2'd1;
                if (r_valid && dout_ready) begin
                    r_valid <= 1'b0;
                end
            end else begin
                r_dout  <= w_sat ^ c_msb;
                r_valid <= 1'b1;
                if (r_valid && !dout_ready) begin
                    r_overrun <= 1'b1;
                end
            end
        end else if (r_valid && dout_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_pdm_decimator.sv
//------------------------------------------------------------------------------
// Module      : tb_pdm_decimator
// Description : Directed, table-driven bench for pdm_decimator.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pdm_decimator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        pdm_in = 1'b0;
    logic [11:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        overrun;

    logic [3:0]  pat = 4'b0101;
    int          n_pass = 0;
    int          n_total = 0;

    typedef struct {
        logic [3:0] pat;
        int         exp;
    } vec_t;

    vec_t vecs[6];

    pdm_decimator #(.OUTPUT_BITS(12), .DECIMATION_LOG2(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pdm_in     (pdm_in),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Repeating 4-bit pattern; a 64-long box over any period-4 pattern is phase independent
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            pdm_in = pat[ph];
            ph = (ph + 1) % 4;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check({tag, " reset dout"}, int'($signed(dout)), 0);
        check({tag, " reset valid"}, int'(dout_valid), 0);
        check({tag, " reset overrun"}, int'(overrun), 0);
    endtask

    // Edges until dout_valid is seen high; -1 if the budget runs out
    task automatic wait_valid(input int limit, output int n);
        int k;
        k = 0;
        n = -1;
        while (k < limit) begin
            @(posedge clk);
            #1;
            k++;
            if (dout_valid) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int k;
        bit found;

        vecs[0] = '{4'b1111,  2047};
        vecs[1] = '{4'b0000, -2048};
        vecs[2] = '{4'b0101,     0};
        vecs[3] = '{4'b0111,  1024};
        vecs[4] = '{4'b0001, -1024};
        vecs[5] = '{4'b0011,     0};

        for (int i = 0; i < 6; i++) begin
            pat = vecs[i].pat;
            dout_ready = 1'b1;
            do_reset($sformatf("v%0d", i));
            wait_valid(400, n);
            check($sformatf("v%0d first latency", i), n, 194);
            check($sformatf("v%0d sample0", i), int'($signed(dout)), vecs[i].exp);
            for (int s = 1; s < 3; s++) begin
                wait_valid(200, n);
                check($sformatf("v%0d spacing%0d", i, s), n, 64);
                check($sformatf("v%0d sample%0d", i, s), int'($signed(dout)), vecs[i].exp);
            end
        end

        // Backpressure long enough to lose one sample
        pat = 4'b1111;
        dout_ready = 1'b1;
        do_reset("bp");
        wait_valid(400, n);
        check("bp first latency", n, 194);
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        repeat (130) @(posedge clk);
        #1;
        check("bp overrun set", int'(overrun), 1);
        check("bp valid held", int'(dout_valid), 1);
        check("bp dout", int'($signed(dout)), 2047);
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp valid drop", int'(dout_valid), 0);
        repeat (5) @(posedge clk);
        #1;
        check("bp overrun sticky", int'(overrun), 1);

        // Ready returns exactly on the edge that loads the next sample
        dout_ready = 1'b0;
        do_reset("edge");
        wait_valid(400, n);
        check("edge first latency", n, 194);
        repeat (63) @(posedge clk);
        #1;
        check("edge stall valid", int'(dout_valid), 1);
        check("edge stall dout", int'($signed(dout)), 2047);
        check("edge stall overrun", int'(overrun), 0);
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        check("edge reload valid", int'(dout_valid), 1);
        check("edge reload overrun", int'(overrun), 0);
        @(posedge clk);
        #1;
        check("edge drain valid", int'(dout_valid), 0);

        // Enable gating stretches the block by the disabled cycles
        dout_ready = 1'b1;
        do_reset("en");
        wait_valid(400, n);
        check("en first latency", n, 194);
        k = 0;
        found = 1'b0;
        while (k < 300 && !found) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 10) en = 1'b0;
            if (k == 60) en = 1'b1;
            if (dout_valid) found = 1'b1;
        end
        en = 1'b1;
        check("en stretched spacing", found ? k : -1, 114);
        check("en stretched value", int'($signed(dout)), 2047);
        wait_valid(200, n);
        check("en normal spacing", n, 64);
        check("en normal value", int'($signed(dout)), 2047);

        // Reset mid-block restarts warm-up
        pat = 4'b0000;
        do_reset("mid pre");
        wait_valid(400, n);
        check("mid pre value", int'($signed(dout)), -2048);
        repeat (20) @(posedge clk);
        pat = 4'b1111;
        do_reset("mid");
        wait_valid(400, n);
        check("mid latency", n, 194);
        check("mid value", int'($signed(dout)), 2047);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
